calc_add_sequencer: RTL and testbench

Sequencing controller for the calculator's signed 8-bit add path. It collects two sign-magnitude operands over a valid/ready entry interface and latches the add/subtract selection with the second operand. It then performs the signed add in one execute cycle and presents a sign-magnitude result with overflow over a valid/ready result interface. It sits between the keypad/entry logic and the display driver, and owns operand registers, sign conversion, and result normalisation.

---
 rtl/calc_add_sequencer_if.sv | 22 ++
 rtl/calc_add_sequencer.sv | 68 ++++++
 tb/tb_calc_add_sequencer.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/calc_add_sequencer_if.sv
// calc_add_sequencer_if: operand entry and result handshake bundle for the add sequencer
interface calc_add_sequencer_if #(parameter int WIDTH = 8);
    logic             key_valid;
    logic             key_ready;
    logic [WIDTH-1:0] key_data;
    logic             key_sign;
    logic             op_sub;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] out;
    logic             out_sign;
    logic             ovf;
    logic             busy;
    modport master (
        output key_valid, key_data, key_sign, op_sub, res_ready,
        input  key_ready, res_valid, out, out_sign, ovf, busy
    );
    modport slave (
        input  key_valid, key_data, key_sign, op_sub, res_ready,
        output key_ready, res_valid, out, out_sign, ovf, busy
    );
endinterface

// File: rtl/calc_add_sequencer.sv
// calc_add_sequencer: collects two sign-magnitude operands, adds/subtracts, presents saturated sign-magnitude result
module calc_add_sequencer #(
    parameter int WIDTH = 8
) (
    input logic                 Clk,
    input logic                 Rst,
    input logic                 clear,
    calc_add_sequencer_if.slave bus
);
    typedef enum logic [1:0] {WAIT_A, WAIT_B, EXEC, HOLD} state_t;
    state_t           state;
    logic [WIDTH-1:0] a_mag, b_mag, out_r;
    logic             a_sgn, b_sgn, sign_r, ovf_r;
    logic [WIDTH+1:0] a_tc, b_tc, sum, mag;
    logic             big;
    assign bus.key_ready = (state == WAIT_A || state == WAIT_B) && !clear;
    assign bus.res_valid = state == HOLD;
    assign bus.busy      = state == EXEC || state == HOLD;
    assign bus.out       = out_r;
    assign bus.out_sign  = sign_r;
    assign bus.ovf       = ovf_r;
    // widen to two's complement, add, then fold back to a saturated magnitude
    always_comb begin
        a_tc = a_sgn ? -{2'b00, a_mag} : {2'b00, a_mag};
        b_tc = b_sgn ? -{2'b00, b_mag} : {2'b00, b_mag};
        sum  = a_tc + b_tc;
        mag  = sum[WIDTH+1] ? -sum : sum;
        big  = |mag[WIDTH+1:WIDTH];
    end
    // sequencer: clear beats every handshake; B's sign is pre-flipped for subtraction
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state  <= WAIT_A;
            a_mag  <= '0;
            a_sgn  <= 1'b0;
            b_mag  <= '0;
            b_sgn  <= 1'b0;
            out_r  <= '0;
            sign_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else if (clear) begin
            state  <= WAIT_A;
            out_r  <= '0;
            sign_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else begin
            case (state)
                WAIT_A: if (bus.key_valid) begin
                    a_mag <= bus.key_data;
                    a_sgn <= bus.key_sign;
                    state <= WAIT_B;
                end
                WAIT_B: if (bus.key_valid) begin
                    b_mag <= bus.key_data;
                    b_sgn <= bus.key_sign ^ bus.op_sub;
                    state <= EXEC;
                end
                EXEC: begin
                    out_r  <= big ? '1 : mag[WIDTH-1:0];
                    sign_r <= sum[WIDTH+1];
                    ovf_r  <= big;
                    state  <= HOLD;
                end
                default: if (bus.res_ready) state <= WAIT_A;
            endcase
        end
    end
endmodule

// File: tb/tb_calc_add_sequencer.sv
// tb_calc_add_sequencer: scoreboard-driven check of the add sequencer
module tb_calc_add_sequencer;
    typedef struct packed {logic [7:0] o; logic s; logic v;} exp_t;
    typedef struct packed {bit sa; logic [7:0] ma; bit sb; logic [7:0] mb; bit sub;} vec_t;
    logic Clk = 1'b0, Rst = 1'b1, clear = 1'b0;
    int   errors = 0, checks = 0;
    exp_t q[$];
    vec_t vecs[7];
    calc_add_sequencer_if #(.WIDTH(8)) bus();
    calc_add_sequencer #(.WIDTH(8)) dut (.Clk(Clk), .Rst(Rst), .clear(clear), .bus(bus));
    initial forever #5 Clk = ~Clk;
    // integer reference: signed add, absolute value, saturate above 255
    function automatic exp_t model(input vec_t v);
        int a, b, r, m;
        exp_t e;
        a = v.sa ? -int'(v.ma) : int'(v.ma);
        b = v.sb ? -int'(v.mb) : int'(v.mb);
        r = v.sub ? a - b : a + b;
        m = r < 0 ? -r : r;
        e.o = m > 255 ? 8'hff : m[7:0];
        e.s = r < 0;
        e.v = m > 255;
        return e;
    endfunction
    task automatic send_key(input bit s, input logic [7:0] m, input bit sub);
        int n = 0;
        bit ok = 0;
        bus.key_valid = 1'b1;
        bus.key_sign  = s;
        bus.key_data  = m;
        bus.op_sub    = sub;
        while (!ok && n < 20) begin
            @(negedge Clk);
            n++;
            if (bus.key_ready) begin
                @(posedge Clk);
                #1;
                ok = 1;
            end
        end
        bus.key_valid = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL key_accept: key_ready=0 for %0d cycles, required 1", n);
        end
    endtask
    task automatic send_ab(input vec_t v);
        q.push_back(model(v));
        send_key(v.sa, v.ma, 1'b0);
        send_key(v.sb, v.mb, v.sub);
    endtask
    task automatic wait_res(output int n);
        n = 0;
        do begin
            @(negedge Clk);
            n++;
        end while (!bus.res_valid && n < 20);
    endtask
    task automatic test_reset();
        #1;
        checks++;
        if ({bus.key_ready, bus.res_valid, bus.busy} !== 3'b100) begin
            errors++;
            $display("FAIL reset_ctrl: ready/valid/busy=%b required 100", {bus.key_ready, bus.res_valid, bus.busy});
        end
        checks++;
        if ({bus.out, bus.out_sign, bus.ovf} !== 10'd0) begin
            errors++;
            $display("FAIL reset_out: out=%0d sign=%b ovf=%b required 0 0 0", bus.out, bus.out_sign, bus.ovf);
        end
        @(posedge Clk);
        #1 Rst = 1'b0;
    endtask
    task automatic test_add(input int lo, input int hi);
        int n;
        for (int i = lo; i <= hi; i++) begin
            send_ab(vecs[i]);
            wait_res(n);
            checks++;
            if (n !== 2) begin
                errors++;
                $display("FAIL latency[%0d]: res_valid after %0d cycles, required 2", i, n);
            end
            checks++;
            if ({bus.out, bus.out_sign, bus.ovf} !== q[0]) begin
                errors++;
                $display("FAIL result[%0d]: out=%0d sign=%b ovf=%b required %0d %b %b", i, bus.out, bus.out_sign, bus.ovf, q[0].o, q[0].s, q[0].v);
            end
            bus.res_ready = 1'b1;
            @(posedge Clk);
            #1 bus.res_ready = 1'b0;
            void'(q.pop_front());
        end
    endtask
    task automatic test_hold_stall();
        int n;
        send_ab('{sa:0, ma:8'd50, sb:0, mb:8'd60, sub:1});
        wait_res(n);
        for (int i = 0; i < 10; i++) begin
            @(posedge Clk);
            #1;
            bus.key_valid = ~bus.key_valid;
            bus.key_data  = 8'($urandom);
            bus.key_sign  = 1'($urandom);
            @(negedge Clk);
            checks++;
            if ({bus.res_valid, bus.busy, bus.key_ready} !== 3'b110 || {bus.out, bus.out_sign, bus.ovf} !== q[0]) begin
                errors++;
                $display("FAIL stall[%0d]: valid/busy/ready=%b out=%0d sign=%b ovf=%b required 110 %0d %b %b", i, {bus.res_valid, bus.busy, bus.key_ready}, bus.out, bus.out_sign, bus.ovf, q[0].o, q[0].s, q[0].v);
            end
        end
        @(posedge Clk);
        #1;
        bus.key_valid = 1'b0;
        bus.res_ready = 1'b1;
        @(posedge Clk);
        #1 bus.res_ready = 1'b0;
        @(negedge Clk);
        checks++;
        if ({bus.res_valid, bus.busy, bus.key_ready} !== 3'b001 || {bus.out, bus.out_sign, bus.ovf} !== q[0]) begin
            errors++;
            $display("FAIL release: valid/busy/ready=%b out=%0d sign=%b required 001 %0d %b", {bus.res_valid, bus.busy, bus.key_ready}, bus.out, bus.out_sign, q[0].o, q[0].s);
        end
        void'(q.pop_front());
        @(posedge Clk);
        #1;
    endtask
    task automatic test_clear();
        send_key(1'b0, 8'd20, 1'b0);
        bus.key_valid = 1'b1;
        bus.key_data  = 8'd33;
        clear = 1'b1;
        @(negedge Clk);
        checks++;
        if (bus.key_ready !== 1'b0) begin
            errors++;
            $display("FAIL clear_gate: key_ready=%b required 0", bus.key_ready);
        end
        @(posedge Clk);
        #1;
        clear = 1'b0;
        bus.key_valid = 1'b0;
        @(negedge Clk);
        checks++;
        if ({bus.res_valid, bus.busy, bus.key_ready, bus.out, bus.out_sign, bus.ovf} !== {3'b001, 10'd0}) begin
            errors++;
            $display("FAIL clear_state: valid/busy/ready=%b out=%0d sign=%b ovf=%b required 001 0 0 0", {bus.res_valid, bus.busy, bus.key_ready}, bus.out, bus.out_sign, bus.ovf);
        end
        @(posedge Clk);
        #1;
    endtask
    task automatic test_rst_exec();
        send_ab('{sa:0, ma:8'd1, sb:0, mb:8'd2, sub:0});
        void'(q.pop_back());
        Rst = 1'b1;
        #1;
        checks++;
        if ({bus.key_ready, bus.res_valid, bus.busy, bus.out, bus.out_sign, bus.ovf} !== {3'b100, 10'd0}) begin
            errors++;
            $display("FAIL rst_exec: ready/valid/busy=%b out=%0d sign=%b ovf=%b required 100 0 0 0", {bus.key_ready, bus.res_valid, bus.busy}, bus.out, bus.out_sign, bus.ovf);
        end
        @(negedge Clk);
        Rst = 1'b0;
        @(posedge Clk);
        #1;
    endtask
    task automatic test_back_to_back();
        vec_t ops[2];
        ops[0] = '{sa:0, ma:8'd3, sb:1, mb:8'd10, sub:0};
        ops[1] = '{sa:1, ma:8'd128, sb:0, mb:8'd127, sub:1};
        bus.res_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            bus.key_valid = 1'b1;
            bus.op_sub    = 1'($urandom);
            bus.key_sign  = 1'($urandom);
            bus.key_data  = 8'($urandom);
            if (c % 4 == 0) begin
                bus.key_sign = ops[c/4].sa;
                bus.key_data = ops[c/4].ma;
            end else if (c % 4 == 1) begin
                bus.key_sign = ops[c/4].sb;
                bus.key_data = ops[c/4].mb;
                bus.op_sub   = ops[c/4].sub;
                q.push_back(model(ops[c/4]));
            end
            @(negedge Clk);
            checks++;
            if ({bus.key_ready, bus.res_valid} !== {c % 4 < 2, c % 4 == 3}) begin
                errors++;
                $display("FAIL b2b_ctrl[%0d]: ready/valid=%b%b required %b%b", c, bus.key_ready, bus.res_valid, c % 4 < 2, c % 4 == 3);
            end
            if (bus.res_valid && q.size() > 0) begin
                checks++;
                if ({bus.out, bus.out_sign, bus.ovf} !== q[0]) begin
                    errors++;
                    $display("FAIL b2b_result[%0d]: out=%0d sign=%b ovf=%b required %0d %b %b", c, bus.out, bus.out_sign, bus.ovf, q[0].o, q[0].s, q[0].v);
                end
                void'(q.pop_front());
            end
            @(posedge Clk);
            #1;
        end
        bus.key_valid = 1'b0;
        bus.res_ready = 1'b0;
    endtask
    initial begin
        bus.key_valid = 1'b0;
        bus.key_data  = '0;
        bus.key_sign  = 1'b0;
        bus.op_sub    = 1'b0;
        bus.res_ready = 1'b0;
        vecs[0] = '{sa:0, ma:8'd100, sb:0, mb:8'd27,  sub:0};
        vecs[1] = '{sa:0, ma:8'd5,   sb:0, mb:8'd9,   sub:1};
        vecs[2] = '{sa:1, ma:8'd5,   sb:1, mb:8'd9,   sub:1};
        vecs[3] = '{sa:1, ma:8'd200, sb:1, mb:8'd100, sub:0};
        vecs[4] = '{sa:0, ma:8'd255, sb:1, mb:8'd255, sub:1};
        vecs[5] = '{sa:0, ma:8'd7,   sb:0, mb:8'd7,   sub:1};
        vecs[6] = '{sa:1, ma:8'd0,   sb:1, mb:8'd0,   sub:0};
        test_reset();
        test_add(0, 6);
        test_hold_stall();
        test_clear();
        test_add(0, 1);
        test_rst_exec();
        test_add(2, 3);
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
